// File: rtl/pipeline_pkg.sv
// Shared definitions for the five-stage pipeline hazard logic.
package pipeline_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_EX  = 2'b11;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Wide enough for the largest legal mult/div occupancy (15).
   localparam int MD_CNT_W = 4;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

endpackage

// File: rtl/fwd_select.sv
// Forwarding select for one source register: EX > MEM > WB > regfile.
module fwd_select
   import pipeline_pkg::*;
(
   input  logic [4:0] src,
   input  logic [4:0] ex_rd,
   input  logic [4:0] mem_rd,
   input  logic [4:0] wb_rd,
   input  logic       ex_en,
   input  logic       mem_en,
   input  logic       wb_en,
   input  logic       ex_load,
   output logic [1:0] sel,
   output logic       ex_hit
);

   logic mem_hit;
   logic wb_hit;

   always_comb begin
      ex_hit  = ex_en  && (ex_rd  == src) && (src != REG_ZERO);
      mem_hit = mem_en && (mem_rd == src) && (src != REG_ZERO);
      wb_hit  = wb_en  && (wb_rd  == src) && (src != REG_ZERO);

      // A load in EX has no result yet; fall through to older stages.
      if (ex_hit && !ex_load) begin
         sel = FWD_EX;
      end else if (mem_hit) begin
         sel = FWD_MEM;
      end else if (wb_hit) begin
         sel = FWD_WB;
      end else begin
         sel = FWD_RF;
      end
   end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline sequencing controller: forwarding, load-use/mult-div stalls, branch squash.
// Define HAZARD_MULDIV_STALL_EN to build the multi-cycle mult/div busy FSM.
module hazard_sequencer
   import pipeline_pkg::*;
#(
   parameter int MULDIV_CYCLES = 4,
   parameter int STALL_CNT_W   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [4:0]             id_rs,
   input  logic [4:0]             id_rt,
   input  logic                   id_uses_rs,
   input  logic                   id_uses_rt,
   input  logic                   id_store_instr,
   input  logic                   id_muldiv,
   input  logic                   id_reads_hilo,
   input  logic [4:0]             ex_rd,
   input  logic [4:0]             mem_rd,
   input  logic [4:0]             wb_rd,
   input  logic                   ex_rf_enable,
   input  logic                   mem_rf_enable,
   input  logic                   wb_rf_enable,
   input  logic                   ex_load_instr,
   input  logic                   ex_branch_taken,
   output logic [1:0]             fwd_a,
   output logic [1:0]             fwd_b,
   output logic [1:0]             fwd_c,
   output logic                   pc_le,
   output logic                   npc_le,
   output logic                   if_id_le,
   output logic                   if_id_clr,
   output logic                   cu_s,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   logic [1:0] sel_a, sel_b, sel_c;
   logic       hit_a, hit_b, unused_hit_c;
   logic       ld_stall;
   logic       md_stall;
   logic       stall;

   fwd_select u_fwd_a (
      .src(id_rs), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
      .ex_en(ex_rf_enable), .mem_en(mem_rf_enable), .wb_en(wb_rf_enable),
      .ex_load(ex_load_instr), .sel(sel_a), .ex_hit(hit_a)
   );

   fwd_select u_fwd_b (
      .src(id_rt), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
      .ex_en(ex_rf_enable), .mem_en(mem_rf_enable), .wb_en(wb_rf_enable),
      .ex_load(ex_load_instr), .sel(sel_b), .ex_hit(hit_b)
   );

   fwd_select u_fwd_c (
      .src(id_rt), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
      .ex_en(ex_rf_enable), .mem_en(mem_rf_enable), .wb_en(wb_rf_enable),
      .ex_load(ex_load_instr), .sel(sel_c), .ex_hit(unused_hit_c)
   );

   // ex_hit already implies ex_rf_enable and a nonzero matching rd.
   assign ld_stall = ex_load_instr &&
                     ((id_uses_rs && hit_a) ||
                      (id_uses_rt && !id_store_instr && hit_b));

   assign stall = ld_stall || md_stall;

`ifdef HAZARD_MULDIV_STALL_EN
   md_state_t             state, state_nx;
   logic [MD_CNT_W-1:0]   md_cnt, md_cnt_nx;

   assign md_stall = (state == MD_BUSY) && (id_reads_hilo || id_muldiv);

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= MD_IDLE;
         md_cnt <= '0;
      end else begin
         state  <= state_nx;
         md_cnt <= md_cnt_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      md_cnt_nx = md_cnt;
      case (state)
         MD_IDLE: begin
            if (id_muldiv && !stall) begin
               state_nx  = MD_BUSY;
               md_cnt_nx = MD_CNT_W'(MULDIV_CYCLES - 1);
            end
         end
         MD_BUSY: begin
            md_cnt_nx = md_cnt - MD_CNT_W'(1);
            if (md_cnt == MD_CNT_W'(1)) begin
               state_nx = MD_IDLE;
            end
         end
         default: begin
            state_nx  = MD_IDLE;
            md_cnt_nx = '0;
         end
      endcase
   end
`else
   logic unused_md;

   assign md_stall  = 1'b0;
   assign unused_md = &{1'b0, id_muldiv, id_reads_hilo, (MULDIV_CYCLES > 0)};
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if (stall && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + STALL_CNT_W'(1);
      end
   end

   // A taken branch still advances PC/NPC during a stall so the target is
   // fetched once the held delay slot is released.
   always_comb begin
      fwd_a     = FWD_RF;
      fwd_b     = FWD_RF;
      fwd_c     = FWD_RF;
      pc_le     = 1'b1;
      npc_le    = 1'b1;
      if_id_le  = 1'b1;
      if_id_clr = 1'b0;
      cu_s      = 1'b1;
      if (!reset) begin
         fwd_a     = sel_a;
         fwd_b     = sel_b;
         fwd_c     = id_store_instr ? sel_c : FWD_RF;
         pc_le     = ex_branch_taken || !stall;
         npc_le    = ex_branch_taken || !stall;
         if_id_le  = !stall;
         if_id_clr = ex_branch_taken && !stall;
         cu_s      = stall;
      end
   end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed self-checking bench for hazard_sequencer (default parameters).
module tb_hazard_sequencer;

   logic        clk;
   logic        reset;
   logic [4:0]  id_rs, id_rt;
   logic        id_uses_rs, id_uses_rt, id_store_instr, id_muldiv, id_reads_hilo;
   logic [4:0]  ex_rd, mem_rd, wb_rd;
   logic        ex_rf_enable, mem_rf_enable, wb_rf_enable;
   logic        ex_load_instr, ex_branch_taken;
   logic [1:0]  fwd_a, fwd_b, fwd_c;
   logic        pc_le, npc_le, if_id_le, if_id_clr, cu_s;
   logic [15:0] stall_cycles;

   int unsigned tests  = 0;
   int unsigned failed = 0;

`ifdef HAZARD_MULDIV_STALL_EN
   localparam bit MD_EN = 1'b1;
`else
   localparam bit MD_EN = 1'b0;
`endif

   hazard_sequencer #(.MULDIV_CYCLES(4), .STALL_CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_store_instr(id_store_instr), .id_muldiv(id_muldiv),
      .id_reads_hilo(id_reads_hilo),
      .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
      .ex_rf_enable(ex_rf_enable), .mem_rf_enable(mem_rf_enable),
      .wb_rf_enable(wb_rf_enable),
      .ex_load_instr(ex_load_instr), .ex_branch_taken(ex_branch_taken),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c),
      .pc_le(pc_le), .npc_le(npc_le), .if_id_le(if_id_le),
      .if_id_clr(if_id_clr), .cu_s(cu_s),
      .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      id_rs = '0; id_rt = '0;
      id_uses_rs = 1'b0; id_uses_rt = 1'b0;
      id_store_instr = 1'b0; id_muldiv = 1'b0; id_reads_hilo = 1'b0;
      ex_rd = '0; mem_rd = '0; wb_rd = '0;
      ex_rf_enable = 1'b0; mem_rf_enable = 1'b0; wb_rf_enable = 1'b0;
      ex_load_instr = 1'b0; ex_branch_taken = 1'b0;
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      // Reset with a forwarding match and a taken branch present.
      ex_rd = 5'd5; ex_rf_enable = 1'b1; id_rs = 5'd5; ex_branch_taken = 1'b1;
      tick();
      tick();
      chk("rst_fwd_a", 32'(fwd_a), 32'd0);
      chk("rst_pc_le", 32'(pc_le), 32'd1);
      chk("rst_if_id_le", 32'(if_id_le), 32'd1);
      chk("rst_if_id_clr", 32'(if_id_clr), 32'd0);
      chk("rst_cu_s", 32'(cu_s), 32'd1);
      chk("rst_stall_cycles", 32'(stall_cycles), 32'd0);

      // Forwarding priority.
      reset = 1'b0;
      idle_inputs();
      ex_rd = 5'd5; mem_rd = 5'd5; ex_rf_enable = 1'b1; mem_rf_enable = 1'b1;
      id_rs = 5'd5; id_rt = 5'd5; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
      #1;
      chk("fwd_a_ex", 32'(fwd_a), 32'd3);
      chk("fwd_b_ex", 32'(fwd_b), 32'd3);
      chk("fwd_cu_s", 32'(cu_s), 32'd0);
      chk("fwd_c_nostore", 32'(fwd_c), 32'd0);
      id_rs = 5'd0;
      #1;
      chk("fwd_a_r0", 32'(fwd_a), 32'd0);
      id_rs = 5'd5; ex_rf_enable = 1'b0; wb_rd = 5'd5; wb_rf_enable = 1'b1;
      #1;
      chk("fwd_a_mem", 32'(fwd_a), 32'd2);
      mem_rf_enable = 1'b0;
      #1;
      chk("fwd_a_wb", 32'(fwd_a), 32'd1);
      tick();

      // Load-use stall: load r8 in EX, ID reads r8 as rs.
      idle_inputs();
      ex_rd = 5'd8; ex_rf_enable = 1'b1; ex_load_instr = 1'b1;
      id_rs = 5'd8; id_uses_rs = 1'b1;
      #1;
      chk("ld_pc_le", 32'(pc_le), 32'd0);
      chk("ld_npc_le", 32'(npc_le), 32'd0);
      chk("ld_if_id_le", 32'(if_id_le), 32'd0);
      chk("ld_cu_s", 32'(cu_s), 32'd1);
      chk("ld_fwd_a", 32'(fwd_a), 32'd0);
      tick();
      ex_rf_enable = 1'b0; ex_load_instr = 1'b0; ex_rd = 5'd0;
      mem_rd = 5'd8; mem_rf_enable = 1'b1;
      #1;
      chk("ld2_fwd_a", 32'(fwd_a), 32'd2);
      chk("ld2_cu_s", 32'(cu_s), 32'd0);
      chk("ld2_pc_le", 32'(pc_le), 32'd1);
      chk("ld2_stall_cycles", 32'(stall_cycles), 32'd1);
      tick();

      // Load feeding store data: no stall, MEM forward next cycle.
      idle_inputs();
      ex_rd = 5'd8; ex_rf_enable = 1'b1; ex_load_instr = 1'b1;
      id_rt = 5'd8; id_uses_rt = 1'b1; id_store_instr = 1'b1;
      #1;
      chk("st_cu_s", 32'(cu_s), 32'd0);
      chk("st_pc_le", 32'(pc_le), 32'd1);
      tick();
      ex_rf_enable = 1'b0; ex_load_instr = 1'b0; ex_rd = 5'd0;
      mem_rd = 5'd8; mem_rf_enable = 1'b1;
      #1;
      chk("st2_fwd_c", 32'(fwd_c), 32'd2);
      tick();

      // Same load with a non-store rt reader does stall.
      idle_inputs();
      ex_rd = 5'd8; ex_rf_enable = 1'b1; ex_load_instr = 1'b1;
      id_rt = 5'd8; id_uses_rt = 1'b1;
      #1;
      chk("ldrt_cu_s", 32'(cu_s), 32'd1);
      tick();
      idle_inputs();
      #1;
      chk("ldrt_stall_cycles", 32'(stall_cycles), 32'd2);

      // Taken branch without stall squashes the fetch.
      ex_branch_taken = 1'b1;
      #1;
      chk("br_pc_le", 32'(pc_le), 32'd1);
      chk("br_if_id_clr", 32'(if_id_clr), 32'd1);
      chk("br_if_id_le", 32'(if_id_le), 32'd1);
      chk("br_cu_s", 32'(cu_s), 32'd0);
      tick();
      ex_branch_taken = 1'b0;
      #1;
      chk("br2_if_id_clr", 32'(if_id_clr), 32'd0);

      // Taken branch coinciding with a load-use stall holds the delay slot.
      ex_branch_taken = 1'b1;
      ex_rd = 5'd9; ex_rf_enable = 1'b1; ex_load_instr = 1'b1;
      id_rs = 5'd9; id_uses_rs = 1'b1;
      #1;
      chk("brst_pc_le", 32'(pc_le), 32'd1);
      chk("brst_npc_le", 32'(npc_le), 32'd1);
      chk("brst_if_id_le", 32'(if_id_le), 32'd0);
      chk("brst_if_id_clr", 32'(if_id_clr), 32'd0);
      chk("brst_cu_s", 32'(cu_s), 32'd1);
      tick();
      idle_inputs();
      #1;
      chk("brst_stall_cycles", 32'(stall_cycles), 32'd3);

      // mult accepted, then mfhi waits MULDIV_CYCLES-1 cycles.
      id_muldiv = 1'b1;
      #1;
      chk("md_accept_cu_s", 32'(cu_s), 32'd0);
      tick();
      id_muldiv = 1'b0; id_reads_hilo = 1'b1;
      #1;
      chk("md_c1_cu_s", 32'(cu_s), 32'(MD_EN));
      tick();
      chk("md_c2_cu_s", 32'(cu_s), 32'(MD_EN));
      tick();
      chk("md_c3_cu_s", 32'(cu_s), 32'(MD_EN));
      chk("md_c3_pc_le", 32'(pc_le), 32'(!MD_EN));
      tick();
      chk("md_c4_cu_s", 32'(cu_s), 32'd0);
      chk("md_stall_cycles", 32'(stall_cycles), MD_EN ? 32'd6 : 32'd3);
      tick();
      idle_inputs();

      // mult in BUSY with taken branch and mflo, then reset mid-BUSY.
      id_muldiv = 1'b1;
      #1;
      tick();
      id_muldiv = 1'b0; id_reads_hilo = 1'b1; ex_branch_taken = 1'b1;
      #1;
      chk("mdbr_pc_le", 32'(pc_le), 32'd1);
      chk("mdbr_if_id_le", 32'(if_id_le), 32'(!MD_EN));
      chk("mdbr_if_id_clr", 32'(if_id_clr), 32'(!MD_EN));
      tick();
      ex_branch_taken = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("mdrst_cu_s", 32'(cu_s), 32'd0);
      chk("mdrst_pc_le", 32'(pc_le), 32'd1);
      chk("mdrst_stall_cycles", 32'(stall_cycles), 32'd0);
      tick();
      chk("mdrst2_cu_s", 32'(cu_s), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
